// File: rtl/uint_add_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uint_add_pipe_pkg
// Purpose  : Shared defaults and the entry record for the buffered unsigned
//            adder. Each FIFO entry holds the carry as its MSB and the sum
//            below it.
// Contents : WIDTH_DEF, CNT_W_DEF, add_entry_t
// Revision : 1.0 - initial release
// ============================================================================
package uint_add_pipe_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int CNT_W_DEF = 8;

    // The layout is {carry, sum}. The top declares the same layout at its
    // own WIDTH.
    typedef struct packed {
        logic                 carry;
        logic [WIDTH_DEF-1:0] sum;
    } add_entry_t;

endpackage : uint_add_pipe_pkg
`default_nettype wire

// File: rtl/uint_add_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : uint_add_fifo2
// Purpose  : Two-entry synchronous FIFO. Occupancy is held in registers, so
//            o_full and o_empty depend only on state.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_push, i_data  - write request and data (ignored while full)
//            i_pop           - read request (ignored while empty)
//            o_data          - oldest entry (reads 0 after reset)
//            o_full, o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module uint_add_fifo2 #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = r_count[1];
    assign o_empty   = (r_count == 2'd0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared so the head reads 0 until the first write.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

endmodule : uint_add_fifo2
`default_nettype wire

// File: rtl/uint_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : uint_add_pipe
// Purpose  : Unsigned WIDTH-bit adder with valid/ready handshakes. Results go
//            into a two-entry output FIFO. A saturating counter counts the
//            accepted additions that produced a carry.
// Ports    : CLK, RESET          - clock, synchronous active-high reset
//            I0, I1              - operands
//            in_valid/in_ready   - input handshake
//            O, COUT             - head entry sum / carry
//            out_valid/out_ready - output handshake
//            ovf_count           - saturating carry counter
//            ovf_clear           - synchronous clear of ovf_count
// Revision : 1.0 - initial release
// ============================================================================
module uint_add_pipe
    import uint_add_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } pipe_entry_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    pipe_entry_t      w_new_entry;
    pipe_entry_t      w_head_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_ovf_count;

    // in_ready depends only on the registered FIFO occupancy.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // WIDTH+1-bit add. The extra MSB is the carry.
    assign w_new_entry = pipe_entry_t'({1'b0, I0} + {1'b0, I1});

    uint_add_fifo2 #(
        .DATA_W (WIDTH + 1)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_push),
        .i_data  (w_new_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign O    = w_head_entry.sum;
    assign COUT = w_head_entry.carry;

    // Clear wins over a simultaneous carry. The count holds at its maximum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= '0;
        end else if (w_push && w_new_entry.carry && (r_ovf_count != c_CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign ovf_count = r_ovf_count;

endmodule : uint_add_pipe
`default_nettype wire

// File: tb/tb_uint_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_uint_add_pipe
// Purpose  : Self-checking bench for uint_add_pipe. It applies directed
//            scenarios, then random traffic. A queue-based reference model
//            supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uint_add_pipe;

    localparam int WIDTH = 3;
    localparam int CNT_W = 2;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clear;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of full-precision sums, oldest first.
    int m_q[$];
    int m_cnt      = 0;
    bit m_zero     = 1'b1;   // head must read 0 (reset seen, nothing written)
    int m_cnt_max  = (1 << CNT_W) - 1;
    int m_mod      = (1 << WIDTH);

    uint_add_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .I0        (I0),
        .I1        (I1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .O         (O),
        .COUT      (COUT),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs for one clock edge, advance the model, and
    // compare every output at the following falling edge.
    task automatic cycle();
        bit xin;
        bit xout;
        int s;
        xin  = !RESET && in_valid && (m_q.size() < 2);
        xout = !RESET && out_ready && (m_q.size() > 0);
        s    = int'(I0) + int'(I1);
        @(posedge CLK);
        if (RESET) begin
            m_q.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else begin
            if (xout) void'(m_q.pop_front());
            if (xin) begin
                m_q.push_back(s);
                m_zero = 1'b0;
            end
            if (ovf_clear) m_cnt = 0;
            else if (xin && s >= m_mod && m_cnt < m_cnt_max) m_cnt++;
        end
        @(negedge CLK);
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("ovf_count", ovf_count, m_cnt);
        if (m_q.size() > 0) begin
            chk("O", O, m_q[0] % m_mod);
            chk("COUT", COUT, m_q[0] / m_mod);
        end else if (m_zero) begin
            chk("O_zero", O, 0);
            chk("COUT_zero", COUT, 0);
        end
    endtask

    task automatic drive(input int a, input int b, input bit v);
        I0       = WIDTH'(a);
        I1       = WIDTH'(b);
        in_valid = v;
    endtask

    initial begin
        RESET = 1'b1; I0 = '0; I1 = '0; in_valid = 1'b0;
        out_ready = 1'b0; ovf_clear = 1'b0;
        @(negedge CLK);
        cycle(); cycle();
        RESET = 1'b0;

        // Single add, immediate drain
        out_ready = 1'b1;
        drive(3, 4, 1); cycle();
        chk("s1_O", O, 7); chk("s1_COUT", COUT, 0); chk("s1_valid", out_valid, 1);
        drive(0, 0, 0); cycle();
        chk("s1_drained", out_valid, 0); chk("s1_cnt", ovf_count, 0);

        // Carry, then clear that coincides with another carry
        drive(5, 6, 1); cycle();
        chk("s2_O", O, 3); chk("s2_COUT", COUT, 1); chk("s2_cnt", ovf_count, 1);
        ovf_clear = 1'b1; drive(7, 7, 1); cycle();
        chk("s2_clr_cnt", ovf_count, 0); chk("s2_clr_O", O, 6); chk("s2_clr_COUT", COUT, 1);
        ovf_clear = 1'b0; drive(0, 0, 0); cycle();

        // Back-pressure: fill, hold the third operand, then release
        out_ready = 1'b0;
        drive(1, 1, 1); cycle();
        drive(2, 2, 1); cycle();
        chk("s3_full", in_ready, 0);
        drive(3, 3, 1); cycle();
        chk("s3_hold_O", O, 2);
        out_ready = 1'b1; cycle();
        chk("s3_O2", O, 4); chk("s3_ready", in_ready, 1);
        cycle();
        chk("s3_O3", O, 6);
        drive(0, 0, 0); cycle();
        chk("s3_empty", out_valid, 0);

        // Streaming at one result per cycle
        for (int k = 1; k <= 5; k++) begin
            drive(k, 0, 1); cycle();
            chk("s4_O", O, k); chk("s4_ready", in_ready, 1);
        end
        drive(0, 0, 0); cycle();

        // Counter saturation with a 2-bit counter
        ovf_clear = 1'b1; cycle(); ovf_clear = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(7, 1, 1); cycle();
            chk("s5_sat", ovf_count, (k < 3) ? k : 3);
        end
        drive(0, 0, 0); cycle();

        // Reset with two entries buffered
        out_ready = 1'b0;
        drive(6, 5, 1); cycle();
        drive(4, 4, 1); cycle();
        drive(0, 0, 0);
        RESET = 1'b1; cycle(); RESET = 1'b0;
        chk("s6_valid", out_valid, 0); chk("s6_O", O, 0); chk("s6_COUT", COUT, 0);
        chk("s6_cnt", ovf_count, 0); chk("s6_ready", in_ready, 1);
        out_ready = 1'b1; cycle(); cycle();
        chk("s6_no_stale", out_valid, 0);

        // Random traffic, including operand changes while nothing transfers
        for (int n = 0; n < 400; n++) begin
            I0        = WIDTH'($urandom);
            I1        = WIDTH'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clear = ($urandom_range(0, 15) == 0);
            RESET     = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uint_add_pipe
`default_nettype wire
